// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between NUM_REQ writeback sources.
// Optional macro WB_BYPASS_EN forwards the in-flight write onto the two read ports.
module regfile_wb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = 5,
    parameter int DATA_W  = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    input  logic [NUM_REQ*IDX_W-1:0]  req_idx_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
    input  logic                      wb_stall_i,
    output logic [IDX_W-1:0]          widx_o,
    output logic [DATA_W-1:0]         wdata_o,
    output logic                      we_o,
    input  logic [IDX_W-1:0]          ridx1_i,
    input  logic [IDX_W-1:0]          ridx2_i,
    input  logic [DATA_W-1:0]         rdata1_i,
    input  logic [DATA_W-1:0]         rdata2_i,
    output logic [DATA_W-1:0]         rdata1_o,
    output logic [DATA_W-1:0]         rdata2_o
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic               r_out_valid;
    logic [IDX_W-1:0]   r_out_idx;
    logic [DATA_W-1:0]  r_out_data;
    logic [PTR_W-1:0]   r_rr_ptr;

    logic [NUM_REQ-1:0] w_grant;
    logic [PTR_W-1:0]   w_gnt_k;
    logic               w_found;
    logic [PTR_W:0]     w_sum;
    logic [PTR_W-1:0]   w_k;
    logic [IDX_W-1:0]   w_sel_idx;
    logic [DATA_W-1:0]  w_sel_data;
    logic [PTR_W-1:0]   w_ptr_nxt;

    // Scan from the round-robin pointer; the first valid requester wins.
    always_comb begin
        w_grant = '0;
        w_gnt_k = '0;
        w_found = 1'b0;
        w_sum   = '0;
        w_k     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_sum = {1'b0, r_rr_ptr} + (PTR_W+1)'(i);
            if (w_sum >= (PTR_W+1)'(NUM_REQ)) begin
                w_sum = w_sum - (PTR_W+1)'(NUM_REQ);
            end
            w_k = w_sum[PTR_W-1:0];
            if (!w_found && req_valid_i[w_k]) begin
                w_found = 1'b1;
                w_gnt_k = w_k;
            end
        end
        if (w_found && rst && !wb_stall_i) begin
            w_grant[w_gnt_k] = 1'b1;
        end
    end

    always_comb begin
        w_sel_idx  = '0;
        w_sel_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_grant[k]) begin
                w_sel_idx  = req_idx_i[k*IDX_W +: IDX_W];
                w_sel_data = req_data_i[k*DATA_W +: DATA_W];
            end
        end
    end

    assign w_ptr_nxt = (w_gnt_k == PTR_W'(NUM_REQ-1)) ? '0 : w_gnt_k + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_out_idx   <= '0;
            r_out_data  <= '0;
            r_rr_ptr    <= '0;
        end else if (!wb_stall_i) begin
            r_out_valid <= |w_grant;
            if (|w_grant) begin
                r_out_idx  <= w_sel_idx;
                r_out_data <= w_sel_data;
                r_rr_ptr   <= w_ptr_nxt;
            end
        end
    end

    assign req_ready_o = w_grant;
    assign widx_o      = r_out_idx;
    assign wdata_o     = r_out_data;
    // Index 0 is hardwired zero: such writes complete the handshake but never reach the regfile.
    assign we_o        = rst & r_out_valid & ~wb_stall_i & (r_out_idx != '0);

`ifdef WB_BYPASS_EN
    assign rdata1_o = (r_out_valid && r_out_idx == ridx1_i && r_out_idx != '0) ? r_out_data : rdata1_i;
    assign rdata2_o = (r_out_valid && r_out_idx == ridx2_i && r_out_idx != '0) ? r_out_data : rdata2_i;
`else
    logic w_unused_ridx;
    assign w_unused_ridx = ^{ridx1_i, ridx2_i};
    assign rdata1_o = rdata1_i;
    assign rdata2_o = rdata2_i;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: accepted writes are queued as expectations and checked on the write port.
module tb_regfile_wb_arbiter;

    localparam int NR = 3;
    localparam int IW = 5;
    localparam int DW = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*IW-1:0]  req_idx;
    logic [NR*DW-1:0]  req_data;
    logic              wb_stall;
    logic [IW-1:0]     widx;
    logic [DW-1:0]     wdata;
    logic              we;
    logic [IW-1:0]     ridx1, ridx2;
    logic [DW-1:0]     rdata1_i, rdata2_i, rdata1_o, rdata2_o;

    logic [IW-1:0]     s_idx [NR];
    logic [DW-1:0]     s_data[NR];
    logic [DW-1:0]     rf[32];

    logic [IW+DW-1:0]  exp_q[$];
    int                n_cmp = 0;
    int                n_fail = 0;

    regfile_wb_arbiter #(.NUM_REQ(NR), .IDX_W(IW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_idx_i(req_idx), .req_data_i(req_data),
        .wb_stall_i(wb_stall),
        .widx_o(widx), .wdata_o(wdata), .we_o(we),
        .ridx1_i(ridx1), .ridx2_i(ridx2),
        .rdata1_i(rdata1_i), .rdata2_i(rdata2_i),
        .rdata1_o(rdata1_o), .rdata2_o(rdata2_o)
    );

    always_comb begin
        req_idx  = '0;
        req_data = '0;
        for (int k = 0; k < NR; k++) begin
            req_idx[k*IW +: IW]  = s_idx[k];
            req_data[k*DW +: DW] = s_data[k];
        end
    end

    // Behavioural register file behind the write port, x0 reads as zero.
    always @(posedge clk) begin
        if (!rst) begin
            for (int r = 0; r < 32; r++) rf[r] <= '0;
        end else if (we && widx != '0) begin
            rf[widx] <= wdata;
        end
    end
    assign rdata1_i = rf[ridx1];

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks one cycle at the falling edge; pushes the expected write for any granted requester.
    task automatic cyc(input string tag, input logic [NR-1:0] exp_rdy, input logic exp_we);
        logic [IW+DW-1:0] e;
        @(negedge clk);
        chk({tag, "_we"}, DW'(we), DW'(exp_we));
        if (exp_we) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $error("FAIL %s_sb observed=write expected=queued entry", tag);
            end else begin
                e = exp_q.pop_front();
                chk({tag, "_widx"}, DW'(widx), DW'(e[IW+DW-1:DW]));
                chk({tag, "_wdata"}, wdata, e[DW-1:0]);
            end
        end
        chk({tag, "_rdy"}, DW'(req_ready), DW'(exp_rdy));
        for (int k = 0; k < NR; k++) begin
            if (exp_rdy[k] && s_idx[k] != '0) exp_q.push_back({s_idx[k], s_data[k]});
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b0;
        req_valid = '1;
        wb_stall  = 1'b0;
        ridx1     = '0;
        ridx2     = '0;
        rdata2_i  = '0;
        for (int k = 0; k < NR; k++) begin
            s_idx[k]  = IW'(k + 1);
            s_data[k] = {$urandom, $urandom_range(32'hFFFF, 0)};
        end

        // Reset held with every requester valid
        repeat (2) begin
            @(negedge clk);
            chk("rst_we", DW'(we), '0);
            chk("rst_rdy", DW'(req_ready), '0);
        end
        chk("rst_widx", DW'(widx), '0);
        nxt();
        rst = 1'b1;

        // Continuous requests rotate 0,1,2,0,1
        cyc("rr0", 3'b001, 1'b0); nxt();
        cyc("rr1", 3'b010, 1'b1); nxt();
        cyc("rr2", 3'b100, 1'b1); nxt();
        cyc("rr3", 3'b001, 1'b1); nxt();
        cyc("rr4", 3'b010, 1'b1); nxt();
        req_valid = '0;
        cyc("rr_drain", 3'b000, 1'b1); nxt();
        cyc("idle", 3'b000, 1'b0); nxt();

        // Single write from req1 and read back through the regfile
        s_idx[1]  = 5'd5;
        s_data[1] = 64'hDEAD_BEEF;
        req_valid = 3'b010;
        cyc("sw_acc", 3'b010, 1'b0); nxt();
        req_valid = '0;
        cyc("sw_we", 3'b000, 1'b1); nxt();
        ridx1 = 5'd5;
        cyc("sw_rb", 3'b000, 1'b0);
        chk("sw_rdata1", rdata1_o, 64'hDEAD_BEEF);
        nxt();

        // Stall holds the write to x7 and blocks a new request
        s_idx[2]  = 5'd7;
        s_data[2] = 64'h77;
        req_valid = 3'b100;
        cyc("st_acc", 3'b100, 1'b0); nxt();
        s_idx[0]  = 5'd8;
        s_data[0] = 64'h88;
        req_valid = 3'b001;
        wb_stall  = 1'b1;
        repeat (3) begin
            cyc("st_hold", 3'b000, 1'b0);
            chk("st_widx", DW'(widx), 64'd7);
            chk("st_wdata", wdata, 64'h77);
            nxt();
        end
        wb_stall = 1'b0;
        cyc("st_rel", 3'b001, 1'b1); nxt();
        req_valid = '0;
        cyc("st_next", 3'b000, 1'b1); nxt();

        // Write to x0 is accepted but never enabled nor bypassed
        s_idx[0]  = 5'd0;
        s_data[0] = 64'h1;
        req_valid = 3'b001;
        ridx1     = 5'd0;
        cyc("x0_acc", 3'b001, 1'b0); nxt();
        req_valid = '0;
        cyc("x0_out", 3'b000, 1'b0);
        chk("x0_rdata1", rdata1_o, 64'h0);
        nxt();

        // In-flight write to x3 against read port 2
        s_idx[1]  = 5'd3;
        s_data[1] = 64'h55;
        req_valid = 3'b010;
        ridx2     = 5'd3;
        rdata2_i  = 64'hAA;
        cyc("bp_acc", 3'b010, 1'b0);
        chk("bp_pre", rdata2_o, 64'hAA);
        nxt();
        req_valid = '0;
        cyc("bp_out", 3'b000, 1'b1);
`ifdef WB_BYPASS_EN
        chk("bp_rdata2", rdata2_o, 64'h55);
`else
        chk("bp_rdata2", rdata2_o, 64'hAA);
`endif
        nxt();
        cyc("bp_after", 3'b000, 1'b0);
        chk("bp_after_rdata2", rdata2_o, 64'hAA);
        nxt();

        chk("sb_empty", DW'(exp_q.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
